// File: rtl/riscv_dmem.sv
// Data memory with a store queue: stores are buffered and committed to the single-ported
// RAM on load-free cycles, while loads forward from the youngest matching queued store.
module riscv_dmem #(
  parameter int BUS_WIDTH = 32,
  parameter int MEM_WORDS = 256,
  parameter int SQ_DEPTH  = 4,
  localparam int IDX_W = $clog2(MEM_WORDS),
  localparam int PTR_W = $clog2(SQ_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 re,
  input  logic                 wr,
  input  logic [BUS_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0] data_in,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]     sq_count,
  output logic                 sq_full,
  output logic                 sq_empty,
  output logic                 misalign_err,
  output logic                 ovf_err
);

  logic [BUS_WIDTH-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]     sq_idx_q  [SQ_DEPTH];
  logic [BUS_WIDTH-1:0] sq_data_q [SQ_DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;
  logic             ovf_q, ovf_d;

  logic             aligned;
  logic [IDX_W-1:0] idx;
  logic             full;
  logic             drain;
  logic             st_ok;
  logic             fwd_hit;
  logic [BUS_WIDTH-1:0] fwd_data;
  logic [PTR_W-1:0] fwd_ptr;
  logic             unused_addr;

  // Upper address bits are ignored so the RAM aliases across the address space.
  assign unused_addr = ^addr[BUS_WIDTH-1:IDX_W+2];

  assign aligned = (addr[1:0] == 2'b00);
  assign idx     = addr[IDX_W+1:2];
  assign full    = (count_q == CNT_W'(SQ_DEPTH));
  assign drain   = !re && (count_q != '0);
  // A full queue still accepts a store when the head leaves on the same edge.
  assign st_ok   = wr && aligned && (!full || drain);

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_ptr  = head_q;
    // Walk oldest to youngest so the last match wins.
    for (int i = 0; i < SQ_DEPTH; i++) begin
      fwd_ptr = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (sq_idx_q[fwd_ptr] == idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = sq_data_q[fwd_ptr];
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (re && aligned) begin
      data_out = fwd_hit ? fwd_data : mem[idx];
    end
  end

  always_comb begin
    head_d     = head_q + PTR_W'(drain);
    tail_d     = tail_q + PTR_W'(st_ok);
    count_d    = count_q + CNT_W'(st_ok) - CNT_W'(drain);
    misalign_d = misalign_q || ((wr || re) && !aligned);
    ovf_d      = ovf_q || (wr && aligned && full && !drain);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      ovf_q      <= ovf_d;
    end
  end

  // Queue payload and RAM carry no reset; a cleared count makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (st_ok) begin
      sq_idx_q[tail_q]  <= idx;
      sq_data_q[tail_q] <= data_in;
    end
    if (drain) begin
      mem[sq_idx_q[head_q]] <= sq_data_q[head_q];
    end
  end

  assign sq_count     = count_q;
  assign sq_full      = full;
  assign sq_empty     = (count_q == '0);
  assign misalign_err = misalign_q;
  assign ovf_err      = ovf_q;

endmodule

// File: doc/riscv_dmem.md
RISCV_DMEM -- requirements
Module: riscv_dmem

Parameters
REQ-001 The block SHALL provide parameter BUS_WIDTH, default 32, as the data and address width.
REQ-002 The block SHALL provide parameter MEM_WORDS, default 256, as the RAM depth in words (power of two).
REQ-003 The block SHALL provide parameter SQ_DEPTH, default 4, as the store-queue depth in entries (power of two).

Interface
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 re  input  1  load strobe from the core.
REQ-007 wr  input  1  store strobe from the core.
REQ-008 addr  input  BUS_WIDTH  byte address of the load or store.
REQ-009 data_in  input  BUS_WIDTH  store data, driven by the core's store-data output.
REQ-010 data_out  output  BUS_WIDTH  load data, driven to the core's load-data input.
REQ-011 sq_count  output  log2(SQ_DEPTH)+1  number of occupied store-queue entries.
REQ-012 sq_full / sq_empty  output  1 each  sq_count==SQ_DEPTH / sq_count==0.
REQ-013 misalign_err  output  1  sticky flag: an access was made with addr[1:0]!=0.
REQ-014 ovf_err  output  1  sticky flag: a store was dropped because the queue was full.

Function
REQ-015 Word index SHALL be addr[log2(MEM_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
REQ-016 A store with addr[1:0]==0 SHALL enqueue {index, data_in} at the queue tail on the edge where wr=1.
REQ-017 Load data SHALL be combinational in the same cycle as re=1, with zero wait states and no stall output.
REQ-018 Load data SHALL come from the youngest queue entry whose index matches; if none matches, it SHALL come from RAM.
REQ-019 data_out SHALL be 0 whenever re=0, or when re=1 with a misaligned addr.
REQ-020 The RAM write port SHALL be single-ported: on a cycle with re=0 and queue not empty, the head entry SHALL be written to RAM and dequeued.
REQ-021 No drain SHALL occur on any cycle with re=1.
REQ-022 A store with enqueue and drain on the same edge SHALL leave sq_count unchanged.
REQ-023 If the queue is full and a drain occurs on the same edge, the store SHALL be accepted (not an overflow).
REQ-024 If the queue is full, re=1, and wr=1, the store SHALL be dropped and ovf_err set; the queue is unchanged.
REQ-025 A misaligned store SHALL NOT enqueue and SHALL set misalign_err; a misaligned load SHALL set misalign_err.
REQ-026 If wr=1 and re=1 in the same cycle, the store SHALL enqueue and the load SHALL return data excluding that store.
REQ-027 Queue pointers SHALL wrap modulo SQ_DEPTH.
REQ-028 Store visibility: a store enqueued at edge N SHALL be returned by a load at index match from cycle N+1 onward, whether forwarded or already committed.
REQ-029 Entries SHALL drain in FIFO order; stores to the same index SHALL commit in program order.
REQ-030 misalign_err and ovf_err SHALL clear only on reset.

Reset
REQ-031 On reset low, asynchronously: head=tail=0, sq_count=0, sq_empty=1, sq_full=0, misalign_err=0, ovf_err=0.
REQ-032 Entries pending in the queue at reset SHALL be discarded and never committed.
REQ-033 RAM contents SHALL be unaffected by reset; data_out SHALL read 0 while re=0.
REQ-034 Reset deasserted SHALL take effect at the next rising clk; no access is accepted before then.

Verification
REQ-035 Store then load: store 0xDEADBEEF to 0x10, then re=1 to 0x10 next cycle -> data_out=0xDEADBEEF; the entry drains when re=0; a later load still returns 0xDEADBEEF.
REQ-036 Forwarding order: stores 0x1 then 0x2 to 0x20 in back-to-back cycles, with re held 1 to another address -> sq_count=2; load 0x20 -> 0x2; after drain RAM[8]=0x2.
REQ-037 Overflow: re held 1, four stores -> sq_full=1; fifth store -> dropped, ovf_err=1, sq_count=4; drop re -> queue drains in 4 cycles.
REQ-038 Full plus drain: queue full, re=0, wr=1 -> store accepted, sq_count stays 4, ovf_err=0.
REQ-039 Misaligned: store to 0x13 -> no enqueue, misalign_err=1; load 0x13 -> data_out=0.
REQ-040 Reset mid-operation: 3 stores queued with re=1, then reset pulsed low between edges -> sq_count=0 immediately; those addresses read their prior RAM values; both error flags are 0.
